bcd_counter_ctrl: RTL

BCD_COUNTER_CTRL -- requirements
Module: bcd_counter_ctrl

---
 rtl/bcd_counter_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bcd_counter_ctrl.sv
// Run/pause/done controller around a DIGITS-wide BCD up-counter with a captured terminal value.
// All outputs are registered; commands take effect on the next rising edge of sys_clk.
module bcd_counter_ctrl #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  wrap_pulse
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   limit_q, limit_d;
  logic           wrap_q, wrap_d;
  logic           running_q, running_d;
  logic           done_q, done_d;

  // Treating any digit >= 9 as the rollover point keeps count BCD-clean.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    wrap_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            limit_d = bcd_sat(limit);
            state_d = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            if (count_q == limit_q) begin
              if (WRAP != 1'b0) begin
                count_d = '0;
                wrap_d  = 1'b1;
              end else begin
                state_d = DONE;
              end
            end else begin
              count_d = bcd_inc(count_q);
            end
          end
          // A terminal tick to DONE outranks a simultaneous pause request.
          if (stop && (state_d == RUN)) state_d = PAUSE;
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          if (start) begin
            count_d = '0;
            limit_d = bcd_sat(limit);
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign count      = count_q;
  assign running    = running_q;
  assign done       = done_q;
  assign wrap_pulse = wrap_q;

endmodule
